// File: rtl/sample_address_sequencer.sv
// -----------------------------------------------------------------------------
// sample_address_sequencer
//
// Generates read addresses for the sample-playback memory. A window
// [start, end] and a step are latched from the configuration side while idle;
// the address then advances by step on every tick from the sample-rate timer.
// In one-shot mode the run ends with a done pulse once the next address would
// leave the window; in loop mode the address returns to start with a wrap
// pulse. stop aborts a run and the address holds its last value.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   cfg_valid  configuration offered (accepted when cfg_valid & cfg_ready)
//   cfg_ready  high only while idle
//   cfg_start  first address of the window
//   cfg_end    last address of the window, inclusive
//   cfg_step   address increment per tick (0 is treated as 1)
//   cfg_loop   1 = loop mode, 0 = one-shot mode
//   tick       advance strobe, one cycle wide
//   stop       abort the run and return to idle
//   address    current memory address
//   addr_valid high while running
//   busy       same as addr_valid
//   wrap       one-cycle pulse when loop mode returns to start
//   done       one-cycle pulse when a one-shot run ends
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module sample_address_sequencer #(
    parameter int ADDR_W = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_start,
    input  logic [ADDR_W-1:0] cfg_end,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              cfg_loop,
    input  logic              tick,
    input  logic              stop,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   address_r;
    logic [ADDR_W-1:0]   address_s;
    logic [ADDR_W-1:0]   start_r;
    logic [ADDR_W-1:0]   start_s;
    logic [ADDR_W-1:0]   end_r;
    logic [ADDR_W-1:0]   end_s;
    logic [STEP_W-1:0]   step_r;
    logic [STEP_W-1:0]   step_s;
    logic                loop_r;
    logic                loop_s;
    logic                wrap_r;
    logic                wrap_s;
    logic                done_r;
    logic                done_s;
    logic                cfg_ready_r;
    logic                cfg_ready_s;
    logic                addr_valid_r;
    logic                addr_valid_s;

    // One extra bit so that stepping past the top of the address space shows
    // up as a carry instead of silently wrapping to a small address.
    logic [ADDR_W:0]     nxt_s;
    logic                in_window_s;

    // Candidate next address and whether it is still inside the window.
    always_comb begin
        nxt_s       = {1'b0, address_r} + (ADDR_W+1)'(step_r);
        in_window_s = (nxt_s[ADDR_W] == 1'b0) && (nxt_s[ADDR_W-1:0] <= end_r);
    end

    // Next-state, next-address and pulse decode.
    always_comb begin
        state_s   = state_r;
        address_s = address_r;
        start_s   = start_r;
        end_s     = end_r;
        step_s    = step_r;
        loop_s    = loop_r;
        wrap_s    = 1'b0;
        done_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // tick and stop have no meaning without a configured window.
                if (cfg_valid) begin
                    start_s   = cfg_start;
                    end_s     = cfg_end;
                    step_s    = (cfg_step == {STEP_W{1'b0}}) ? STEP_W'(1'b1) : cfg_step;
                    loop_s    = cfg_loop;
                    address_s = cfg_start;
                    state_s   = ST_RUN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // stop takes priority over a simultaneous tick.
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (tick) begin
                    if (in_window_s) begin
                        address_s = nxt_s[ADDR_W-1:0];
                    end else if (loop_r) begin
                        address_s = start_r;
                        wrap_s    = 1'b1;
                    end else begin
                        // Address holds the last emitted value.
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                address_s = {ADDR_W{1'b0}};
            end
        endcase

        cfg_ready_s  = (state_s == ST_IDLE);
        addr_valid_s = (state_s == ST_RUN);
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            address_r    <= {ADDR_W{1'b0}};
            start_r      <= {ADDR_W{1'b0}};
            end_r        <= {ADDR_W{1'b0}};
            step_r       <= {STEP_W{1'b0}};
            loop_r       <= 1'b0;
            wrap_r       <= 1'b0;
            done_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
            addr_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            address_r    <= address_s;
            start_r      <= start_s;
            end_r        <= end_s;
            step_r       <= step_s;
            loop_r       <= loop_s;
            wrap_r       <= wrap_s;
            done_r       <= done_s;
            cfg_ready_r  <= cfg_ready_s;
            addr_valid_r <= addr_valid_s;
        end
    end

    assign address    = address_r;
    assign addr_valid = addr_valid_r;
    assign busy       = addr_valid_r;
    assign wrap       = wrap_r;
    assign done       = done_r;
    assign cfg_ready  = cfg_ready_r;

endmodule

// File: tb/tb_sample_address_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sample_address_sequencer
//
// Directed bench for sample_address_sequencer (ADDR_W=16, STEP_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so each sample shows the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_sample_address_sequencer;

    localparam int ADDR_W = 16;
    localparam int STEP_W = 4;

    logic              clk;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_start;
    logic [ADDR_W-1:0] cfg_end;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_loop;
    logic              tick;
    logic              stop;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              busy;
    logic              wrap;
    logic              done;

    int check_count;
    int fail_count;

    sample_address_sequencer #(
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_end    (cfg_end),
        .cfg_step   (cfg_step),
        .cfg_loop   (cfg_loop),
        .tick       (tick),
        .stop       (stop),
        .address    (address),
        .addr_valid (addr_valid),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Status bits packed as {cfg_ready, addr_valid, busy, wrap, done} plus address.
    task automatic check_out(input string tag, input logic [15:0] exp_addr,
                             input logic exp_ready, input logic exp_valid,
                             input logic exp_wrap, input logic exp_done);
        check_value({tag, ".addr"}, 32'(address), 32'(exp_addr));
        check_value({tag, ".status"},
                    32'({cfg_ready, addr_valid, busy, wrap, done}),
                    32'({exp_ready, exp_valid, exp_valid, exp_wrap, exp_done}));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a configuration for one cycle; afterwards the run has started.
    task automatic start_run(input logic [15:0] s, input logic [15:0] e,
                             input logic [3:0] st, input logic lp);
        cfg_valid = 1'b1;
        cfg_start = s;
        cfg_end   = e;
        cfg_step  = st;
        cfg_loop  = lp;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_start = 16'h0000;
        cfg_end   = 16'h0000;
        cfg_step  = 4'h0;
        cfg_loop  = 1'b0;
        tick      = 1'b0;
        stop      = 1'b0;

        // Reset hold: reset overrides cfg_valid and tick.
        cfg_valid = 1'b1;
        cfg_start = 16'h0005;
        cfg_end   = 16'h0009;
        cfg_step  = 4'h1;
        tick      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_out("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cfg_valid = 1'b0;
        tick      = 1'b0;
        reset     = 1'b1;
        cycle();
        check_out("idle_after_reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // One-shot 0..3 step 1, five ticks.
        start_run(16'h0000, 16'h0003, 4'h1, 1'b0);
        check_out("oneshot_first", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        cycle(); check_out("oneshot_t1", 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("oneshot_t2", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("oneshot_t3", 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("oneshot_done", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(); check_out("oneshot_idle_tick", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
        tick = 1'b0;

        // Loop 2..10 step 3: 2,5,8,2(wrap),5.
        start_run(16'h0002, 16'h000A, 4'h3, 1'b1);
        check_out("loop_first", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        cycle(); check_out("loop_t1", 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("loop_t2", 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("loop_wrap", 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(); check_out("loop_after_wrap", 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b0;
        stop = 1'b1;
        cycle(); check_out("loop_stop", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // Overflow at top of range: FFFD + 4 carries out, run ends.
        start_run(16'hFFFD, 16'hFFFF, 4'h4, 1'b0);
        check_out("ovf_first", 16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        cycle(); check_out("ovf_done", 16'hFFFD, 1'b1, 1'b0, 1'b0, 1'b1);
        tick = 1'b0;
        cycle(); check_out("ovf_idle", 16'hFFFD, 1'b1, 1'b0, 1'b0, 1'b0);

        // start > end, one-shot then loop.
        start_run(16'h0008, 16'h0004, 4'h1, 1'b0);
        check_out("inv_os_first", 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        cycle(); check_out("inv_os_done", 16'h0008, 1'b1, 1'b0, 1'b0, 1'b1);
        tick = 1'b0;
        start_run(16'h0008, 16'h0004, 4'h2, 1'b1);
        tick = 1'b1;
        cycle(); check_out("inv_loop_wrap", 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0);
        tick = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // End not on step grid: 0,4,8 then done (10 never emitted).
        start_run(16'h0000, 16'h000A, 4'h4, 1'b0);
        tick = 1'b1;
        cycle(); check_out("grid_t1", 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("grid_t2", 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("grid_done", 16'h0008, 1'b1, 1'b0, 1'b0, 1'b1);
        tick = 1'b0;

        // Full sweep, step 0 treated as 1, tick every cycle.
        start_run(16'h0000, 16'hFFFF, 4'h0, 1'b1);
        check_out("sweep_first", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        for (int i = 1; i < 65536; i++) begin
            cycle();
            check_value("sweep", 32'({wrap, done, address}), 32'({1'b0, 1'b0, 16'(i)}));
        end
        cycle(); check_out("sweep_wrap", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(); check_out("sweep_after_wrap", 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // stop and tick together at address 5.
        start_run(16'h0000, 16'h0014, 4'h1, 1'b0);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check_out("coll_at5", 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        cycle(); check_out("coll_stop_tick", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        tick = 1'b0;

        // cfg_valid while running is ignored.
        start_run(16'h0007, 16'h0009, 4'h1, 1'b0);
        cfg_valid = 1'b1;
        cfg_start = 16'h0064;
        cfg_end   = 16'h00C8;
        cycle(); check_out("run_cfg_ignored", 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        tick = 1'b1;
        cycle(); check_out("run_cfg_t1", 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("run_cfg_t2", 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); check_out("run_cfg_done", 16'h0009, 1'b1, 1'b0, 1'b0, 1'b1);
        tick = 1'b0;

        // Back-to-back: accept in the cycle right after done.
        start_run(16'h0030, 16'h0030, 4'h1, 1'b0);
        tick = 1'b1;
        cycle(); check_out("b2b_done", 16'h0030, 1'b1, 1'b0, 1'b0, 1'b1);
        tick = 1'b0;
        start_run(16'h0040, 16'h0050, 4'h1, 1'b0);
        check_out("b2b_accept", 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-run.
        tick = 1'b1;
        cycle(); cycle();
        check_out("midrun_pre", 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        cycle(); check_out("midrun_reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick  = 1'b0;
        cycle(); check_out("midrun_idle", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
